// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: register index and pipeline control state
package cpu_types_pkg;

    typedef logic [4:0] regbits;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } ctrl_state_t;

    localparam logic [15:0] STALL_MAX = 16'hFFFF;

endpackage

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline hazard controller: stalls, flushes, halt and stall counter
module pipeline_ctrl
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        mem_dREN,
    input  logic        mem_dWEN,
    input  logic        mem_halt,
    input  logic        ex_dREN,
    input  regbits      ex_wsel,
    input  regbits      id_rs,
    input  regbits      id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_pcsrc,
    output logic        pc_en,
    output logic        if_en,
    output logic        if_flush,
    output logic        id_en,
    output logic        id_flush,
    output logic        ex_en,
    output logic        ex_flush,
    output logic        mem_en,
    output logic        mem_flush,
    output logic        halted,
    output logic [15:0] stall_count
);

    ctrl_state_t state;
    ctrl_state_t next_state;
    logic        data_wait;
    logic        load_use;

    assign data_wait = (mem_dREN | mem_dWEN) & ~dhit;
    assign load_use  = ex_dREN && (ex_wsel != 5'd0) &&
                       ((ex_wsel == id_rs) || (id_uses_rt && (ex_wsel == id_rt)));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= RUN;
            stall_count <= 16'd0;
        end else begin
            state <= next_state;
            if ((state != HALT) && !pc_en && (stall_count != STALL_MAX))
                stall_count <= stall_count + 16'd1;
        end
    end

    // A pending redirect during a data wait is simply held off: the EX latch
    // keeps ex_pcsrc asserted, so the flush falls out on the dhit cycle.
    always_comb begin
        next_state = state;
        pc_en      = 1'b0;
        if_en      = 1'b0;
        if_flush   = 1'b0;
        id_en      = 1'b0;
        id_flush   = 1'b0;
        ex_en      = 1'b0;
        ex_flush   = 1'b0;
        mem_en     = 1'b0;
        mem_flush  = 1'b0;
        halted     = 1'b0;
        if (RST) begin
            next_state = RUN;
        end else if (state == HALT) begin
            halted = 1'b1;
        end else if (data_wait) begin
            next_state = DWAIT;
        end else begin
            next_state = mem_halt ? HALT : RUN;
            ex_en      = 1'b1;
            mem_en     = 1'b1;
            if (ex_pcsrc) begin
                pc_en    = 1'b1;
                if_flush = 1'b1;
                id_flush = 1'b1;
            end else if (load_use) begin
                id_flush = 1'b1;
            end else if (!ihit) begin
                if_flush = 1'b1;
                id_en    = 1'b1;
            end else begin
                pc_en = 1'b1;
                if_en = 1'b1;
                id_en = 1'b1;
            end
        end
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have ports CLK (in, 1, rising-edge clock) and RST (in, 1, synchronous active-high reset); one clock, reset is synchronous and active-high.
REQ-002 SHALL have inputs ihit (1, instruction fetch complete) and dhit (1, data access complete).
REQ-003 SHALL have inputs mem_dREN and mem_dWEN (1 each, MEM-stage data request) and mem_halt (1, halt reached MEM).
REQ-004 SHALL have inputs ex_dREN (1, load in EX), ex_wsel (5, EX destination register), id_rs and id_rt (5 each, ID source registers) and id_uses_rt (1).
REQ-005 SHALL have input ex_pcsrc (1, taken branch or jump resolved in EX).
REQ-006 SHALL have outputs pc_en, if_en, if_flush, id_en, id_flush, ex_en, ex_flush, mem_en and mem_flush (1 each); these drive the en/flush pins of the PC and the four pipeline latches.
REQ-007 SHALL have outputs halted (1) and stall_count (16, stall-cycle counter).

Function
REQ-008 SHALL hold registered state ctrl_state_t with values RUN, DWAIT and HALT; enable and flush outputs are combinational from state and inputs.
REQ-009 Priority, highest first: RST, HALT, data wait, redirect, load-use, fetch wait, run.
REQ-010 HALT: all en=0, all flush=0, pc_en=0, halted=1.
REQ-011 Data wait applies when (mem_dREN|mem_dWEN) and !dhit. All en=0, all flush=0, pc_en=0. Next state is DWAIT.
REQ-012 DWAIT→RUN on the cycle dhit=1; that cycle is evaluated as RUN with the memory access complete.
REQ-013 Redirect applies when ex_pcsrc=1 and no data wait. pc_en=1, if_flush=1, id_flush=1, ex_en=1, mem_en=1.
REQ-014 Load-use applies when ex_dREN=1, ex_wsel!=0 and (ex_wsel==id_rs or (id_uses_rt and ex_wsel==id_rt)). pc_en=0, if_en=0, id_flush=1, ex_en=1, mem_en=1.
REQ-015 Fetch wait applies when ihit=0 and no higher case is active. pc_en=0, if_flush=1, id_en=1, ex_en=1, mem_en=1.
REQ-016 Run: pc_en and all en=1, all flush=0.
REQ-017 Flush SHALL override en at a latch; an output SHALL never assert en and flush together.
REQ-018 mem_halt=1 with no data wait SHALL move RUN→HALT at the next edge. HALT SHALL be left only by RST.
REQ-019 If mem_halt and a data wait occur together, the controller SHALL enter DWAIT first, then HALT after dhit.
REQ-020 ex_pcsrc during a data wait SHALL be deferred; the flush issues on the dhit cycle, because the EX latch holds its contents.
REQ-021 stall_count SHALL increment each cycle pc_en=0 while RST=0 and state!=HALT, and SHALL saturate at 16'hFFFF.

Reset
REQ-022 While RST=1: state=RUN, stall_count=0, all en=0, all flush=0, pc_en=0, halted=0.
REQ-023 RST asserted mid-DWAIT or in HALT SHALL return to RUN on the next edge with the counter cleared.

Structure
REQ-024 ctrl_state_t SHALL be defined in cpu_types_pkg; the 5-bit register index type SHALL be the existing package regbits type.
REQ-025 The block SHALL have no sub-modules: one always_ff for state and counter, one always_comb for outputs.

Verification
REQ-026 Load-use: ex_dREN=1, ex_wsel=5, id_rs=5 → pc_en=0, if_en=0, id_flush=1, ex_en=1 for exactly 1 cycle; stall_count increments by 1.
REQ-027 Load-use with ex_wsel=0, id_rs=0 → no stall; pc_en=1.
REQ-028 mem_dREN=1, dhit=0 for 3 cycles then 1 → all en=0 for 3 cycles; DWAIT→RUN on the 4th cycle; stall_count=3.
REQ-029 ex_pcsrc=1 together with a data wait → no flush while waiting; if_flush=id_flush=1 exactly on the dhit cycle.
REQ-030 mem_halt=1 → halted=1 from the next cycle, all en=0, counter frozen; RST=1 for 1 cycle → RUN, stall_count=0.
REQ-031 Force 70000 stall cycles with ihit=0 → stall_count=16'hFFFF and it holds.
